// File: rtl/pea_pkg.sv
// Shared types and constants for the polynomial evaluation core.
package pea_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_INSTR_WIDTH  = 8;
    localparam int unsigned DEF_DEG_WIDTH    = 6;
    localparam int unsigned DEF_STATUS_WIDTH = 4;

    localparam int unsigned STAT_OK      = 0;
    localparam int unsigned STAT_OVF     = 1;
    localparam int unsigned STAT_ILLEGAL = 2;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_EVAL    = 2'b01,
        OP_HALT    = 2'b10,
        OP_ILLEGAL = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_READ_X     = 4'd2,
        ST_CAPTURE_X  = 4'd3,
        ST_READ_C     = 4'd4,
        ST_ACC        = 4'd5,
        ST_WRITE_RES  = 4'd6,
        ST_WRITE_STAT = 4'd7,
        ST_HALT       = 4'd8
    } state_e;

endpackage

// File: rtl/pea_mac.sv
// Horner step: acc*x + coef at double width, truncated, with signed overflow flag.
module pea_mac #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] coef,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  ovf
);

    localparam int unsigned FULL_WIDTH = 2 * DATA_WIDTH;

    logic signed [FULL_WIDTH-1:0] prod;
    logic signed [FULL_WIDTH-1:0] full;

    // Product and sum cannot wrap at double width; overflow means bits above the
    // truncated sign bit disagree with it.
    always_comb begin
        prod = $signed({{DATA_WIDTH{acc[DATA_WIDTH-1]}}, acc})
             * $signed({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x});
        full = prod + $signed({{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef});
        res  = full[DATA_WIDTH-1:0];
        ovf  = (full[FULL_WIDTH-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){full[DATA_WIDTH-1]}});
    end

endmodule

// File: rtl/pea_horner_core.sv
// FIFO-fed Horner polynomial evaluator: one result and one status word per EVAL.
module pea_horner_core
    import pea_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int unsigned DEG_WIDTH    = DEF_DEG_WIDTH,
    parameter int unsigned STATUS_WIDTH = DEF_STATUS_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    empty_instruction,
    input  logic [INSTR_WIDTH-1:0]  instruction,
    output logic                    read_enable_instruction,
    input  logic                    empty_data,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    read_enable_data,
    input  logic                    full_result,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    write_enable_result,
    input  logic                    full_status,
    output logic [STATUS_WIDTH-1:0] status,
    output logic                    write_enable_status,
    output logic [DATA_WIDTH-1:0]   sum
);

    state_e                  state, state_n;
    logic [DATA_WIDTH-1:0]   x_q, x_n;
    logic [DATA_WIDTH-1:0]   sum_n;
    logic [DEG_WIDTH-1:0]    count, count_n;
    logic [DEG_WIDTH-1:0]    degree, degree_n;
    logic                    ovf_q, ovf_n;
    logic [DATA_WIDTH-1:0]   result_n;
    logic [STATUS_WIDTH-1:0] status_n;

    logic [DATA_WIDTH-1:0]   mac_res;
    logic                    mac_ovf;
    opcode_e                 opcode;

    assign opcode = opcode_e'(instruction[INSTR_WIDTH-1 -: 2]);

    pea_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .acc  (sum),
        .x    (x_q),
        .coef (data_in),
        .res  (mac_res),
        .ovf  (mac_ovf)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers; result is loaded on the last ACC so it is valid while WRITE_RES pushes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            sum    <= '0;
            count  <= '0;
            degree <= '0;
            ovf_q  <= 1'b0;
            result <= '0;
            status <= '0;
        end else begin
            x_q    <= x_n;
            sum    <= sum_n;
            count  <= count_n;
            degree <= degree_n;
            ovf_q  <= ovf_n;
            result <= result_n;
            status <= status_n;
        end
    end

    // Next-state, datapath updates and FIFO handshakes gated by empty/full.
    always_comb begin
        state_n                 = state;
        x_n                     = x_q;
        sum_n                   = sum;
        count_n                 = count;
        degree_n                = degree;
        ovf_n                   = ovf_q;
        result_n                = result;
        status_n                = status;
        read_enable_instruction = 1'b0;
        read_enable_data        = 1'b0;
        write_enable_result     = 1'b0;
        write_enable_status     = 1'b0;

        case (state)
            ST_FETCH: begin
                if (!empty_instruction) begin
                    read_enable_instruction = 1'b1;
                    state_n                 = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_NOP:  state_n = ST_FETCH;
                    OP_EVAL: begin
                        degree_n = instruction[DEG_WIDTH-1:0];
                        state_n  = ST_READ_X;
                    end
                    OP_HALT: state_n = ST_HALT;
                    default: begin
                        status_n = STATUS_WIDTH'(STAT_ILLEGAL);
                        state_n  = ST_WRITE_STAT;
                    end
                endcase
            end
            ST_READ_X: begin
                if (!empty_data) begin
                    read_enable_data = 1'b1;
                    state_n          = ST_CAPTURE_X;
                end
            end
            ST_CAPTURE_X: begin
                x_n     = data_in;
                sum_n   = '0;
                count_n = degree;
                ovf_n   = 1'b0;
                state_n = ST_READ_C;
            end
            ST_READ_C: begin
                if (!empty_data) begin
                    read_enable_data = 1'b1;
                    state_n          = ST_ACC;
                end
            end
            ST_ACC: begin
                sum_n = mac_res;
                ovf_n = ovf_q | mac_ovf;
                if (count == '0) begin
                    result_n = mac_res;
                    state_n  = ST_WRITE_RES;
                end else begin
                    count_n = count - DEG_WIDTH'(1);
                    state_n = ST_READ_C;
                end
            end
            ST_WRITE_RES: begin
                if (!full_result) begin
                    write_enable_result = 1'b1;
                    status_n = ovf_q ? STATUS_WIDTH'(STAT_OVF) : STATUS_WIDTH'(STAT_OK);
                    state_n  = ST_WRITE_STAT;
                end
            end
            ST_WRITE_STAT: begin
                if (!full_status) begin
                    write_enable_status = 1'b1;
                    state_n             = ST_FETCH;
                end
            end
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_pea_horner_core.sv
// Directed bench for pea_horner_core with FIFO models and a Horner scoreboard.
module tb_pea_horner_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        empty_instruction;
    logic [7:0]  instruction;
    logic        read_enable_instruction;
    logic        empty_data;
    logic [31:0] data_in;
    logic        read_enable_data;
    logic        full_result;
    logic [31:0] result;
    logic        write_enable_result;
    logic        full_status;
    logic [3:0]  status;
    logic        write_enable_status;
    logic [31:0] sum;

    logic [7:0]  iq[$];
    logic [31:0] dq[$];
    logic [7:0]  pi[$];
    logic [31:0] pd[$];
    logic [31:0] exp_res[$];
    logic [3:0]  exp_stat[$];
    logic [3:0]  got_stat[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int data_pops = 0;
    int exp_pops = 0;
    int res_writes = 0;
    int stat_writes = 0;
    int last_ipop_cyc = 0;
    int last_res_cyc = 0;
    int last_stat_cyc = 0;
    logic [31:0] last_result = '0;
    logic [3:0]  last_status = '0;

    pea_horner_core dut (
        .clock                   (clock),
        .reset                   (reset),
        .empty_instruction       (empty_instruction),
        .instruction             (instruction),
        .read_enable_instruction (read_enable_instruction),
        .empty_data              (empty_data),
        .data_in                 (data_in),
        .read_enable_data        (read_enable_data),
        .full_result             (full_result),
        .result                  (result),
        .write_enable_result     (write_enable_result),
        .full_status             (full_status),
        .status                  (status),
        .write_enable_status     (write_enable_status),
        .sum                     (sum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference evaluation of the staged program (pi/pd) straight from the Horner definition.
    task automatic model_run();
        int      k;
        int      deg;
        int      t;
        longint  x, acc, c, p;
        bit      ovf;
        logic [1:0] op;
        k = 0;
        exp_pops = 0;
        for (int i = 0; i < pi.size(); i++) begin
            op  = pi[i][7:6];
            deg = int'(pi[i][5:0]);
            if (op == 2'b10) break;
            if (op == 2'b11) begin
                exp_stat.push_back(4'd2);
            end else if (op == 2'b01) begin
                x   = $signed(pd[k]);
                acc = 0;
                ovf = 1'b0;
                for (int j = 0; j <= deg; j++) begin
                    c = $signed(pd[k + 1 + j]);
                    p = acc * x + c;
                    t = int'(p);
                    if (longint'(t) != p) ovf = 1'b1;
                    acc = t;
                end
                exp_res.push_back(acc[31:0]);
                exp_stat.push_back(ovf ? 4'd1 : 4'd0);
                k        += deg + 2;
                exp_pops += deg + 2;
            end
        end
    endtask

    task automatic push_all();
        foreach (pi[i]) iq.push_back(pi[i]);
        foreach (pd[i]) dq.push_back(pd[i]);
        pi.delete();
        pd.delete();
    endtask

    task automatic start_scenario();
        data_pops = 0;
        got_stat.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_res.size() != 0 || exp_stat.size() != 0 || iq.size() != 0 ||
                dq.size() != 0) && n < 1000) begin
            step(1);
            n++;
        end
        vectors++;
        if (n >= 1000) begin
            miscompares++;
            $display("FAIL %s_timeout: waited %0d cycles, required drain", name, n);
        end
        step(3);
    endtask

    // FIFO flags follow the queues, updated just after the active edge.
    always @(posedge clock) begin
        #1;
        empty_instruction = (iq.size() == 0);
        empty_data        = (dq.size() == 0);
    end

    // Monitor: FIFO pops, write capture, scoreboard comparison.
    always @(negedge clock) begin
        cyc++;
        if (read_enable_instruction) begin
            chk("pop_instr_when_empty", 64'(empty_instruction), 64'd0);
            if (iq.size() > 0) instruction = iq.pop_front();
            last_ipop_cyc = cyc;
        end
        if (read_enable_data) begin
            chk("pop_data_when_empty", 64'(empty_data), 64'd0);
            if (dq.size() > 0) data_in = dq.pop_front();
            data_pops++;
        end
        if (write_enable_result) begin
            chk("write_result_when_full", 64'(full_result), 64'd0);
            res_writes++;
            last_result  = result;
            last_res_cyc = cyc;
            if (exp_res.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got write of %0h, required none", result);
            end else begin
                chk("result", 64'(result), 64'(exp_res.pop_front()));
            end
        end
        if (write_enable_status) begin
            chk("write_status_when_full", 64'(full_status), 64'd0);
            stat_writes++;
            last_status   = status;
            last_stat_cyc = cyc;
            got_stat.push_back(status);
            if (exp_stat.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_status: got write of %0h, required none", status);
            end else begin
                chk("status", 64'(status), 64'(exp_stat.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int r0, s0;
        reset             = 1'b0;
        full_result       = 1'b0;
        full_status       = 1'b0;
        instruction       = '0;
        data_in           = '0;
        empty_instruction = 1'b1;
        empty_data        = 1'b1;
        step(3);

        // reset state
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_enables", 64'({read_enable_instruction, read_enable_data,
                                write_enable_result, write_enable_status}), 64'd0);
        reset = 1'b1;
        step(2);

        // EVAL deg 2, x=3, 2,1,5 -> 26, with latency
        start_scenario();
        pi.push_back(8'h42);
        pd.push_back(32'd3); pd.push_back(32'd2); pd.push_back(32'd1); pd.push_back(32'd5);
        model_run();
        push_all();
        wait_drain("deg2");
        chk("deg2_result", 64'(last_result), 64'd26);
        chk("deg2_status", 64'(last_status), 64'd0);
        chk("deg2_pops", 64'(data_pops), 64'(exp_pops));
        chk("deg2_pops_lit", 64'(data_pops), 64'd4);
        chk("deg2_res_latency", 64'(last_res_cyc - last_ipop_cyc), 64'd10);
        chk("deg2_stat_latency", 64'(last_stat_cyc - last_ipop_cyc), 64'd11);

        // EVAL deg 0, x=7, -4
        start_scenario();
        pi.push_back(8'h40);
        pd.push_back(32'd7); pd.push_back(32'hFFFF_FFFC);
        model_run();
        push_all();
        wait_drain("deg0");
        chk("deg0_result", 64'(last_result), 64'hFFFF_FFFC);
        chk("deg0_status", 64'(last_status), 64'd0);
        chk("deg0_pops", 64'(data_pops), 64'd2);

        // overflow: x=2^30, 4,0 -> 2^32 truncated
        start_scenario();
        pi.push_back(8'h41);
        pd.push_back(32'h4000_0000); pd.push_back(32'd4); pd.push_back(32'd0);
        model_run();
        push_all();
        wait_drain("ovf");
        chk("ovf_result", 64'(last_result), 64'd0);
        chk("ovf_status", 64'(last_status), 64'd1);

        // illegal opcode then EVAL deg 1, x=2, 3,1
        start_scenario();
        r0 = res_writes;
        s0 = stat_writes;
        pi.push_back(8'hC0); pi.push_back(8'h41);
        pd.push_back(32'd2); pd.push_back(32'd3); pd.push_back(32'd1);
        model_run();
        push_all();
        wait_drain("illegal");
        chk("illegal_res_writes", 64'(res_writes - r0), 64'd1);
        chk("illegal_stat_writes", 64'(stat_writes - s0), 64'd2);
        if (got_stat.size() == 2) begin
            chk("illegal_first_status", 64'(got_stat[0]), 64'd2);
        end else begin
            chk("illegal_status_count", 64'(got_stat.size()), 64'd2);
        end
        chk("illegal_eval_result", 64'(last_result), 64'd7);
        chk("illegal_eval_status", 64'(last_status), 64'd0);
        chk("illegal_pops", 64'(data_pops), 64'd3);

        // result FIFO full during WRITE_RES
        start_scenario();
        r0 = res_writes;
        full_result = 1'b1;
        pi.push_back(8'h42);
        pd.push_back(32'd3); pd.push_back(32'd2); pd.push_back(32'd1); pd.push_back(32'd5);
        model_run();
        push_all();
        for (int n = 0; n < 200 && data_pops < 4; n++) step(1);
        chk("full_pops", 64'(data_pops), 64'd4);
        step(2);
        for (int n = 0; n < 5; n++) begin
            chk("full_no_write", 64'(write_enable_result), 64'd0);
            step(1);
        end
        chk("full_no_write_count", 64'(res_writes - r0), 64'd0);
        full_result = 1'b0;
        wait_drain("full");
        chk("full_write_count", 64'(res_writes - r0), 64'd1);
        chk("full_result", 64'(last_result), 64'd26);

        // data FIFO runs dry mid-coefficients
        start_scenario();
        pi.push_back(8'h42);
        pd.push_back(32'd3); pd.push_back(32'd2); pd.push_back(32'd1); pd.push_back(32'd5);
        model_run();
        iq.push_back(8'h42);
        dq.push_back(32'd3); dq.push_back(32'd2); dq.push_back(32'd1);
        pi.delete();
        pd.delete();
        r0 = res_writes;
        step(15);
        chk("stall_pops", 64'(data_pops), 64'd3);
        chk("stall_sum", 64'(sum), 64'd7);
        chk("stall_no_write", 64'(res_writes - r0), 64'd0);
        dq.push_back(32'd5);
        wait_drain("stall");
        chk("stall_result", 64'(last_result), 64'd26);
        chk("stall_status", 64'(last_status), 64'd0);

        // reset during READ_C, then NOP, HALT, EVAL
        start_scenario();
        iq.push_back(8'h43);
        dq.push_back(32'd3); dq.push_back(32'd9);
        for (int n = 0; n < 200 && data_pops < 2; n++) step(1);
        step(3);
        chk("pre_reset_sum", 64'(sum), 64'd9);
        reset = 1'b0;
        #1;
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_status", 64'(status), 64'd0);
        chk("abort_enables", 64'({read_enable_instruction, read_enable_data,
                                  write_enable_result, write_enable_status}), 64'd0);
        iq.delete();
        dq.delete();
        exp_res.delete();
        exp_stat.delete();
        r0 = res_writes;
        s0 = stat_writes;
        pi.push_back(8'h00); pi.push_back(8'h80); pi.push_back(8'h41);
        pd.push_back(32'd2); pd.push_back(32'd3); pd.push_back(32'd1);
        model_run();
        push_all();
        step(2);
        data_pops = 0;
        reset = 1'b1;
        step(40);
        chk("halt_pops", 64'(data_pops), 64'(exp_pops));
        chk("halt_pops_lit", 64'(data_pops), 64'd0);
        chk("halt_instr_left", 64'(iq.size()), 64'd1);
        chk("halt_data_left", 64'(dq.size()), 64'd3);
        chk("halt_res_writes", 64'(res_writes - r0), 64'd0);
        chk("halt_stat_writes", 64'(stat_writes - s0), 64'd0);
        chk("halt_read_enable", 64'(read_enable_instruction), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
